// File: rtl/sram_ctrlr_if.sv
// Request/response bundle between the SRAM arbiter (master) and one bank controller (slave).
// The byte-lane enable field exists only when SRAM_CTRLR_BYTE_EN is defined.
interface sram_ctrlr_if;
    logic        mem;
    logic        rw;
    logic [15:0] din;
    logic [19:0] adr;
`ifdef SRAM_CTRLR_BYTE_EN
    logic [1:0]  be;
`endif
    logic        ready;
    logic [15:0] dout;

`ifdef SRAM_CTRLR_BYTE_EN
    modport master (output mem, rw, din, adr, be, input ready, dout);
    modport slave  (input mem, rw, din, adr, be, output ready, dout);
`else
    modport master (output mem, rw, din, adr, input ready, dout);
    modport slave  (input mem, rw, din, adr, output ready, dout);
`endif
endinterface

// File: rtl/sram_ctrlr.sv
// Async 16-bit x 1M SRAM bank controller; every SRAM pin and the handshake are registered.
// Optional byte lanes: define SRAM_CTRLR_BYTE_EN to add req_if.be (bit1 upper, bit0 lower).
module sram_ctrlr #(
    parameter int unsigned WAIT_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    sram_ctrlr_if.slave req_if,
    output logic [19:0] o_sram_adr,
    output logic [15:0] o_sram_dq,
    output logic        o_sram_dq_oe,
    input  logic [15:0] i_sram_dq,
    output logic        o_sram_ce_n,
    output logic        o_sram_oe_n,
    output logic        o_sram_we_n,
    output logic        o_sram_ub_n,
    output logic        o_sram_lb_n
);
    typedef enum logic [2:0] {IDLE, READ, WSETUP, WPULSE, WHOLD} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYC - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [19:0] adr_q, adr_d;
    logic [15:0] dq_q, dq_d;
    logic [15:0] dout_q, dout_d;
    logic        ready_q, ready_d;
    logic        dq_oe_q, dq_oe_d;
    logic        ce_n_q, ce_n_d;
    logic        oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d;
    logic        ub_n_q, ub_n_d;
    logic        lb_n_q, lb_n_d;
    logic [1:0]  lane_n;

    // Lane strobes are registered at acceptance and held, so they double as the latched be.
`ifdef SRAM_CTRLR_BYTE_EN
    assign lane_n = ~req_if.be;
`else
    assign lane_n = 2'b00;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        dq_d    = dq_q;
        dout_d  = dout_q;
        ready_d = ready_q;
        dq_oe_d = dq_oe_q;
        ce_n_d  = ce_n_q;
        oe_n_d  = oe_n_q;
        we_n_d  = we_n_q;
        ub_n_d  = ub_n_q;
        lb_n_d  = lb_n_q;
        case (state_q)
            IDLE: begin
                if (req_if.mem) begin
                    adr_d   = req_if.adr;
                    ready_d = 1'b0;
                    ce_n_d  = 1'b0;
                    ub_n_d  = lane_n[1];
                    lb_n_d  = lane_n[0];
                    if (req_if.rw) begin
                        state_d = READ;
                        oe_n_d  = 1'b0;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = WSETUP;
                        dq_d    = req_if.din;
                        dq_oe_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                    dout_d  = i_sram_dq;
                    ready_d = 1'b1;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    ub_n_d  = 1'b1;
                    lb_n_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WSETUP: begin
                state_d = WPULSE;
                we_n_d  = 1'b0;
                cnt_d   = CNT_LOAD;
            end
            WPULSE: begin
                if (cnt_q == 4'd0) begin
                    state_d = WHOLD;
                    we_n_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WHOLD: begin
                state_d = IDLE;
                ready_d = 1'b1;
                dq_oe_d = 1'b0;
                ce_n_d  = 1'b1;
                ub_n_d  = 1'b1;
                lb_n_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
                dq_oe_d = 1'b0;
                ce_n_d  = 1'b1;
                oe_n_d  = 1'b1;
                we_n_d  = 1'b1;
                ub_n_d  = 1'b1;
                lb_n_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            adr_q   <= 20'd0;
            dq_q    <= 16'd0;
            dout_q  <= 16'd0;
            ready_q <= 1'b1;
            dq_oe_q <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            ub_n_q  <= 1'b1;
            lb_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            dq_q    <= dq_d;
            dout_q  <= dout_d;
            ready_q <= ready_d;
            dq_oe_q <= dq_oe_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            ub_n_q  <= ub_n_d;
            lb_n_q  <= lb_n_d;
        end
    end

    assign req_if.ready = ready_q;
    assign req_if.dout  = dout_q;
    assign o_sram_adr   = adr_q;
    assign o_sram_dq    = dq_q;
    assign o_sram_dq_oe = dq_oe_q;
    assign o_sram_ce_n  = ce_n_q;
    assign o_sram_oe_n  = oe_n_q;
    assign o_sram_we_n  = we_n_q;
    assign o_sram_ub_n  = ub_n_q;
    assign o_sram_lb_n  = lb_n_q;
endmodule

// File: tb/tb_sram_ctrlr.sv
// Scoreboard bench for sram_ctrlr (WAIT_CYC=2) with a small async SRAM model on the pins.
module tb_sram_ctrlr;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [19:0] sram_adr;
    logic [15:0] sram_dq, sram_rd;
    logic        dq_oe, ce_n, oe_n, we_n, ub_n, lb_n;
    logic [15:0] sram_m [0:255];

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit          rd;
        logic [19:0] adr;
        logic [15:0] dq;
        logic [15:0] dout;
        logic [1:0]  lanes;
        int          busy;
        int          we;
    } exp_t;
    exp_t        sb[$];
    logic [15:0] exp_dout = 16'h0000;

    sram_ctrlr_if bus();

    sram_ctrlr #(.WAIT_CYC(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_if       (bus),
        .o_sram_adr   (sram_adr),
        .o_sram_dq    (sram_dq),
        .o_sram_dq_oe (dq_oe),
        .i_sram_dq    (sram_rd),
        .o_sram_ce_n  (ce_n),
        .o_sram_oe_n  (oe_n),
        .o_sram_we_n  (we_n),
        .o_sram_ub_n  (ub_n),
        .o_sram_lb_n  (lb_n)
    );

    always #5 clk = ~clk;

    // Async SRAM: reads while CE/OE low, writes latch on the rising edge of WE.
    always_comb sram_rd = (!ce_n && !oe_n) ? sram_m[sram_adr[7:0]] : 16'h0000;
    always @(posedge we_n) if (!ce_n) sram_m[sram_adr[7:0]] = sram_dq;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor: accumulates each busy window and checks it against the scoreboard when ready rises.
    int          m_busy = 0, m_we = 0, m_oe_cyc = 0;
    bit          m_ovl = 0, m_adr_chg = 0, m_dq_chg = 0, m_prev_ready = 1;
    logic [19:0] m_adr;
    logic [15:0] m_dq;
    logic [1:0]  m_lanes;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            m_busy = 0; m_we = 0; m_oe_cyc = 0;
            m_ovl = 0; m_adr_chg = 0; m_dq_chg = 0; m_prev_ready = 1;
        end else begin
            if (!bus.ready) begin
                if (m_busy == 0) begin
                    m_adr   = sram_adr;
                    m_lanes = {ub_n, lb_n};
                end
                m_busy++;
                if (!we_n) m_we++;
                if (dq_oe && !oe_n) m_ovl = 1;
                if (sram_adr !== m_adr) m_adr_chg = 1;
                if (dq_oe) begin
                    if (m_oe_cyc == 0) m_dq = sram_dq;
                    else if (sram_dq !== m_dq) m_dq_chg = 1;
                    m_oe_cyc++;
                end
            end
            if (bus.ready && !m_prev_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_completion", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("busy_cycles", m_busy, e.busy);
                    chk("we_low_cycles", m_we, e.we);
                    chk("dq_oe_oe_overlap", {31'd0, m_ovl}, 0);
                    chk("sram_adr", sram_adr, e.adr);
                    chk("adr_stable", {31'd0, m_adr_chg}, 0);
                    chk("lanes", m_lanes, e.lanes);
                    chk("dout", bus.dout, e.dout);
                    if (e.rd) begin
                        chk("read_dq_oe_cycles", m_oe_cyc, 0);
                    end else begin
                        chk("write_dq_oe_cycles", m_oe_cyc, e.busy);
                        chk("write_dq", m_dq, e.dq);
                        chk("write_dq_stable", {31'd0, m_dq_chg}, 0);
                    end
                end
                m_busy = 0; m_we = 0; m_oe_cyc = 0;
                m_ovl = 0; m_adr_chg = 0; m_dq_chg = 0;
            end
            m_prev_ready = bus.ready;
        end
    end

    // For reads, d is the hand-computed data expected back from the SRAM.
    task automatic issue(input bit rd, input logic [19:0] a, input logic [15:0] d,
                         input logic [1:0] be, input bit hold, input bit push);
        exp_t e;
        int   t = 0;
        @(negedge clk);
        while (!bus.ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("ready_timeout", 0, 1);
        bus.mem = 1'b1;
        bus.rw  = rd;
        bus.adr = a;
        bus.din = d;
`ifdef SRAM_CTRLR_BYTE_EN
        bus.be  = be;
        e.lanes = ~be;
`else
        e.lanes = 2'b00;
`endif
        if (rd) exp_dout = d;
        e.rd   = rd;
        e.adr  = a;
        e.dq   = d;
        e.dout = exp_dout;
        e.busy = rd ? 2 : 4;
        e.we   = rd ? 0 : 2;
        if (push) sb.push_back(e);
        @(posedge clk);
        #2;
        chk("accepted", {31'd0, bus.ready}, 0);
        bus.adr = ~a;
        bus.din = ~d;
        bus.rw  = ~rd;
        if (!hold) bus.mem = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) sram_m[i] = 16'h0000;
        bus.mem = 1'b0;
        bus.rw  = 1'b0;
        bus.din = 16'h0000;
        bus.adr = 20'h00000;
`ifdef SRAM_CTRLR_BYTE_EN
        bus.be  = 2'b11;
`endif
        repeat (3) @(posedge clk);
        #3;
        chk("rst_ready", {31'd0, bus.ready}, 1);
        chk("rst_strobes", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'b11111);
        chk("rst_dq_oe", {31'd0, dq_oe}, 0);
        chk("rst_dout", bus.dout, 16'h0000);
        chk("rst_adr", sram_adr, 20'h00000);
        chk("rst_dq", sram_dq, 16'h0000);
        rst_n = 1'b1;

        issue(0, 20'h12345, 16'hBEEF, 2'b11, 0, 1);
        issue(1, 20'h12345, 16'hBEEF, 2'b11, 0, 1);
        drain();

        // Continuous i_mem with inputs scrambled while busy.
        issue(0, 20'h00001, 16'hA5A5, 2'b11, 1, 1);
        issue(1, 20'h00001, 16'hA5A5, 2'b11, 1, 1);
        issue(0, 20'h00001, 16'h5A5A, 2'b11, 1, 1);
        issue(1, 20'h00001, 16'h5A5A, 2'b11, 0, 1);
        drain();
        chk("sram_model_0x00001", sram_m[8'h01], 16'h5A5A);

        // Reset while WE is low: the access is abandoned.
        issue(0, 20'h00077, 16'h1234, 2'b11, 0, 0);
        @(posedge clk);
        #2;
        chk("wpulse_we_n", {31'd0, we_n}, 0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_strobes", {ce_n, we_n, oe_n}, 3'b111);
        chk("async_rst_dq_oe", {31'd0, dq_oe}, 0);
        chk("async_rst_ready", {31'd0, bus.ready}, 1);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        exp_dout = 16'h0000;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, bus.ready}, 1);
        chk("post_rst_dout", bus.dout, 16'h0000);
        chk("post_rst_no_pending", sb.size(), 0);

        issue(1, 20'h12345, 16'hBEEF, 2'b11, 0, 1);
        drain();

`ifdef SRAM_CTRLR_BYTE_EN
        issue(0, 20'h00002, 16'hC3C3, 2'b01, 0, 1);
        issue(0, 20'h00003, 16'h7E7E, 2'b00, 0, 1);
        issue(1, 20'h00002, 16'hC3C3, 2'b10, 0, 1);
        drain();
`endif
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
